// File: rtl/lcd_value_formatter.sv
//==============================================================================
// Module      : lcd_value_formatter
// Description : Converts two unsigned readings in tenths of a unit into six
//               ASCII digit bytes (tens, ones, tenths per channel) for the
//               PmodCLP LCD driver. A single shared double-dabble datapath
//               processes one shift per clock, first for channel 1 and then
//               for channel 2. All six digits and both overflow flags are
//               committed on the same edge, so the display never shows a
//               half-updated value.
// Ports       : CLK      - system clock, rising edge
//               btnr     - synchronous active-high reset
//               start    - conversion request, accepted when busy==0
//               val_1/2  - channel values in tenths (VAL_W bits)
//               busy     - conversion in progress
//               done     - one-cycle pulse, outputs updated on this edge
//               ovf_1/2  - channel was clamped to MAX_VAL on last conversion
//               d10_x, d1_x, d10ths_x - ASCII digits per channel
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_value_formatter #(
    parameter int VAL_W    = 10,
    parameter int MAX_VAL  = 999,
    parameter int BLANK_LZ = 0
) (
    input  logic             CLK,
    input  logic             btnr,
    input  logic             start,
    input  logic [VAL_W-1:0] val_1,
    input  logic [VAL_W-1:0] val_2,
    output logic             busy,
    output logic             done,
    output logic             ovf_1,
    output logic             ovf_2,
    output logic [7:0]       d10_1,
    output logic [7:0]       d1_1,
    output logic [7:0]       d10ths_1,
    output logic [7:0]       d10_2,
    output logic [7:0]       d1_2,
    output logic [7:0]       d10ths_2
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV1 = 2'd1;
    localparam logic [1:0] S_CONV2 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [VAL_W-1:0] C_MAX  = VAL_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(VAL_W - 1);
    localparam logic [CNT_W-1:0] C_END  = CNT_W'(VAL_W);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [VAL_W-1:0] r_bin;      // shift source for the channel being converted
    logic [VAL_W-1:0] r_hold2;    // clamped channel 2 value waiting for its turn
    logic [11:0]      r_bcd;
    logic [11:0]      r_res1;     // finished channel 1 BCD, held until commit
    logic             r_povf1;
    logic             r_povf2;
    logic             r_ovf1;
    logic             r_ovf2;
    logic [7:0]       r_d10_1, r_d1_1, r_d10ths_1;
    logic [7:0]       r_d10_2, r_d1_2, r_d10ths_2;

    logic             w_accept;
    logic             w_ovf1, w_ovf2;
    logic [VAL_W-1:0] w_clamp1, w_clamp2;
    logic [11:0]      w_adj;
    logic [11:0]      w_bcd_next;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_ovf1   = (val_1 > C_MAX);
    assign w_ovf2   = (val_2 > C_MAX);
    assign w_clamp1 = w_ovf1 ? C_MAX : val_1;
    assign w_clamp2 = w_ovf2 ? C_MAX : val_2;

    // Add-3 correction on each BCD nibble before the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                  (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
    end

    assign w_bcd_next = {w_adj[10:0], r_bin[VAL_W-1]};

    function automatic logic [7:0] f_ascii(input logic [3:0] n);
        return {4'h3, n};
    endfunction

    function automatic logic [7:0] f_tens(input logic [3:0] n);
        return ((BLANK_LZ != 0) && (n == 4'd0)) ? 8'h20 : {4'h3, n};
    endfunction

    always_ff @(posedge CLK) begin
        if (btnr) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bin      <= '0;
            r_hold2    <= '0;
            r_bcd      <= '0;
            r_res1     <= '0;
            r_povf1    <= 1'b0;
            r_povf2    <= 1'b0;
            r_ovf1     <= 1'b0;
            r_ovf2     <= 1'b0;
            r_d10_1    <= 8'h30;
            r_d1_1     <= 8'h30;
            r_d10ths_1 <= 8'h30;
            r_d10_2    <= 8'h30;
            r_d1_2     <= 8'h30;
            r_d10ths_2 <= 8'h30;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_CONV1;
                        r_cnt   <= '0;
                        r_bcd   <= '0;
                        r_bin   <= w_clamp1;
                        r_hold2 <= w_clamp2;
                        r_povf1 <= w_ovf1;
                        r_povf2 <= w_ovf2;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CONV1: begin
                    if (r_cnt == C_LAST) begin
                        // Last channel 1 shift: park the result and reload
                        // the shared datapath with channel 2.
                        r_res1  <= w_bcd_next;
                        r_bcd   <= '0;
                        r_bin   <= r_hold2;
                        r_cnt   <= '0;
                        r_state <= S_CONV2;
                    end else begin
                        r_bcd <= w_bcd_next;
                        r_bin <= r_bin << 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CONV2: begin
                    if (r_cnt == C_END) begin
                        // All shifts complete: commit every output together.
                        r_d10_1    <= f_tens(r_res1[11:8]);
                        r_d1_1     <= f_ascii(r_res1[7:4]);
                        r_d10ths_1 <= f_ascii(r_res1[3:0]);
                        r_d10_2    <= f_tens(r_bcd[11:8]);
                        r_d1_2     <= f_ascii(r_bcd[7:4]);
                        r_d10ths_2 <= f_ascii(r_bcd[3:0]);
                        r_ovf1     <= r_povf1;
                        r_ovf2     <= r_povf2;
                        r_cnt      <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_bcd <= w_bcd_next;
                        r_bin <= r_bin << 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_CONV1) || (r_state == S_CONV2);
    assign done     = (r_state == S_DONE);
    assign ovf_1    = r_ovf1;
    assign ovf_2    = r_ovf2;
    assign d10_1    = r_d10_1;
    assign d1_1     = r_d1_1;
    assign d10ths_1 = r_d10ths_1;
    assign d10_2    = r_d10_2;
    assign d1_2     = r_d1_2;
    assign d10ths_2 = r_d10ths_2;

endmodule

`default_nettype wire

// File: tb/tb_lcd_value_formatter.sv
//==============================================================================
// Module      : tb_lcd_value_formatter
// Description : Self-checking bench for lcd_value_formatter. Two instances
//               share all stimulus: one with leading-zero blanking off, one
//               with it on. Expected digits come from decimal arithmetic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lcd_value_formatter;

    logic       clk = 1'b0;
    logic       btnr = 1'b1;
    logic       start = 1'b0;
    logic [9:0] val_1 = '0;
    logic [9:0] val_2 = '0;

    logic       a_busy, a_done, a_ovf_1, a_ovf_2;
    logic [7:0] a_d10_1, a_d1_1, a_d10ths_1, a_d10_2, a_d1_2, a_d10ths_2;
    logic       b_busy, b_done, b_ovf_1, b_ovf_2;
    logic [7:0] b_d10_1, b_d1_1, b_d10ths_1, b_d10_2, b_d1_2, b_d10ths_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_value_formatter #(.VAL_W(10), .MAX_VAL(999), .BLANK_LZ(0)) dut_a (
        .CLK(clk), .btnr(btnr), .start(start), .val_1(val_1), .val_2(val_2),
        .busy(a_busy), .done(a_done), .ovf_1(a_ovf_1), .ovf_2(a_ovf_2),
        .d10_1(a_d10_1), .d1_1(a_d1_1), .d10ths_1(a_d10ths_1),
        .d10_2(a_d10_2), .d1_2(a_d1_2), .d10ths_2(a_d10ths_2)
    );

    lcd_value_formatter #(.VAL_W(10), .MAX_VAL(999), .BLANK_LZ(1)) dut_b (
        .CLK(clk), .btnr(btnr), .start(start), .val_1(val_1), .val_2(val_2),
        .busy(b_busy), .done(b_done), .ovf_1(b_ovf_1), .ovf_2(b_ovf_2),
        .d10_1(b_d10_1), .d1_1(b_d1_1), .d10ths_1(b_d10ths_1),
        .d10_2(b_d10_2), .d1_2(b_d1_2), .d10ths_2(b_d10ths_2)
    );

    wire [47:0] a_dig = {a_d10_1, a_d1_1, a_d10ths_1, a_d10_2, a_d1_2, a_d10ths_2};
    wire [47:0] b_dig = {b_d10_1, b_d1_1, b_d10ths_1, b_d10_2, b_d1_2, b_d10ths_2};

    // Reference: saturate, then split into decimal digits.
    function automatic logic [23:0] ref_digits(input int v, input bit blank);
        int c, t, o, f;
        logic [7:0] tens;
        c = (v > 999) ? 999 : v;
        t = c / 100;
        o = (c / 10) % 10;
        f = c % 10;
        tens = (blank && t == 0) ? 8'h20 : 8'(8'h30 + t);
        return {tens, 8'(8'h30 + o), 8'(8'h30 + f)};
    endfunction

    function automatic logic [47:0] ref_pair(input int v1, input int v2, input bit blank);
        return {ref_digits(v1, blank), ref_digits(v2, blank)};
    endfunction

    // Drive one start pulse and count edges until done (bounded at 40).
    task automatic convert(input int v1, input int v2, output int lat, output logic busy_n1);
        val_1 = 10'(v1);
        val_2 = 10'(v2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n1 = a_busy;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (a_done) break;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        btnr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btnr = 1'b0;
        checks++;
        if (a_dig !== 48'h303030303030 || b_dig !== 48'h303030303030) begin
            errors++;
            $display("FAIL reset_digits: got a=%h b=%h, want 303030303030", a_dig, b_dig);
        end
        checks++;
        if ({a_busy, a_done, a_ovf_1, a_ovf_2, b_busy, b_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b ovf=%b%b, want all 0",
                     a_busy, a_done, a_ovf_1, a_ovf_2);
        end
        idle(2);
    endtask

    task automatic test_basic;
        int lat;
        logic bz;
        logic [47:0] snap;
        convert(123, 405, lat, bz);
        checks++;
        if (bz !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b, want 1", bz);
        end
        checks++;
        if (lat !== 21) begin
            errors++; $display("FAIL basic_latency: got %0d, want 21", lat);
        end
        checks++;
        if (a_dig !== 48'h313233343035) begin
            errors++; $display("FAIL basic_digits: got %h, want 313233343035", a_dig);
        end
        checks++;
        if ({a_ovf_1, a_ovf_2, a_busy} !== 3'b000) begin
            errors++; $display("FAIL basic_flags: got ovf=%b%b busy=%b, want 000", a_ovf_1, a_ovf_2, a_busy);
        end
        snap = a_dig;
        idle(1);
        checks++;
        if (a_done !== 1'b0) begin
            errors++; $display("FAIL done_width: got %b, want 0", a_done);
        end
        idle(5);
        checks++;
        if (a_dig !== snap || a_busy !== 1'b0) begin
            errors++; $display("FAIL hold: got %h busy=%b, want %h busy=0", a_dig, a_busy, snap);
        end
    endtask

    task automatic test_clamp;
        int lat;
        logic bz;
        convert(1023, 0, lat, bz);
        checks++;
        if (lat !== 21 || a_dig !== 48'h393939303030) begin
            errors++; $display("FAIL clamp_digits: got lat=%0d %h, want 21 393939303030", lat, a_dig);
        end
        checks++;
        if (a_ovf_1 !== 1'b1 || a_ovf_2 !== 1'b0) begin
            errors++; $display("FAIL clamp_ovf: got %b%b, want 10", a_ovf_1, a_ovf_2);
        end
        checks++;
        if (b_dig !== 48'h393939203030) begin
            errors++; $display("FAIL clamp_blank: got %h, want 393939203030", b_dig);
        end
        idle(3);
    endtask

    task automatic test_ignore_busy;
        int ndone, first;
        logic busy_lost;
        ndone = 0; first = -1; busy_lost = 1'b0;
        val_1 = 10'd111; val_2 = 10'd222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        val_1 = 10'd555; val_2 = 10'd666; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 6; e <= 45; e++) begin
            @(posedge clk); #1;
            if (a_done) begin ndone++; if (first < 0) first = e; end
            if (e < 21 && !a_busy) busy_lost = 1'b1;
        end
        checks++;
        if (ndone !== 1 || first !== 21) begin
            errors++; $display("FAIL ignore_done: got count=%0d at=%0d, want 1 at 21", ndone, first);
        end
        checks++;
        if (a_dig !== ref_pair(111, 222, 1'b0) || busy_lost) begin
            errors++; $display("FAIL ignore_digits: got %h busy_lost=%b, want %h", a_dig, busy_lost,
                               ref_pair(111, 222, 1'b0));
        end
    endtask

    task automatic test_reset_abort;
        int lat, nd;
        logic bz;
        nd = 0;
        val_1 = 10'd999; val_2 = 10'd999; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        btnr = 1'b1;
        @(posedge clk); #1;
        btnr = 1'b0;
        checks++;
        if (a_dig !== 48'h303030303030 || {a_busy, a_done, a_ovf_1, a_ovf_2} !== 4'b0) begin
            errors++; $display("FAIL abort_state: got %h flags=%b%b%b%b, want 303030303030 0000",
                               a_dig, a_busy, a_done, a_ovf_1, a_ovf_2);
        end
        for (int e = 0; e < 25; e++) begin
            @(posedge clk); #1;
            if (a_done) nd++;
        end
        checks++;
        if (nd !== 0 || a_dig !== 48'h303030303030) begin
            errors++; $display("FAIL abort_no_done: got dones=%0d %h, want 0 303030303030", nd, a_dig);
        end
        convert(12, 34, lat, bz);
        checks++;
        if (lat !== 21 || a_dig !== 48'h303132303334) begin
            errors++; $display("FAIL abort_recover: got lat=%0d %h, want 21 303132303334", lat, a_dig);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int lat;
        logic bz;
        convert(57, 100, lat, bz);
        checks++;
        if (lat !== 21 || b_dig !== 48'h203537313030 || a_dig !== 48'h303537313030) begin
            errors++; $display("FAIL blank_digits: got lat=%0d b=%h a=%h, want 21 203537313030 303537313030",
                               lat, b_dig, a_dig);
        end
        // Still in the DONE cycle: this start must be accepted immediately.
        convert(804, 9, lat, bz);
        checks++;
        if (bz !== 1'b1 || lat !== 21 || a_dig !== ref_pair(804, 9, 1'b0)) begin
            errors++; $display("FAIL back_to_back: got busy=%b lat=%0d %h, want 1 21 %h",
                               bz, lat, a_dig, ref_pair(804, 9, 1'b0));
        end
    endtask

    task automatic test_random;
        int lat, v1, v2;
        logic bz;
        for (int i = 0; i < 16; i++) begin
            v1 = (i == 0) ? 999 : (i == 1) ? 1000 : int'($urandom_range(0, 1023));
            v2 = (i == 0) ? 1000 : (i == 1) ? 999 : int'($urandom_range(0, 1023));
            convert(v1, v2, lat, bz);
            checks++;
            if (lat !== 21 || a_dig !== ref_pair(v1, v2, 1'b0) || b_dig !== ref_pair(v1, v2, 1'b1)) begin
                errors++; $display("FAIL random_digits[%0d] %0d/%0d: got lat=%0d a=%h b=%h, want 21 %h %h",
                                   i, v1, v2, lat, a_dig, b_dig, ref_pair(v1, v2, 1'b0), ref_pair(v1, v2, 1'b1));
            end
            checks++;
            if (a_ovf_1 !== (v1 > 999) || a_ovf_2 !== (v2 > 999)) begin
                errors++; $display("FAIL random_ovf[%0d]: got %b%b, want %b%b",
                                   i, a_ovf_1, a_ovf_2, (v1 > 999), (v2 > 999));
            end
            if (i % 3 == 0) idle(2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
